axi4_lite_regbank: RTL and testbench
====================================

AXI4_LITE_REGBANK -- requirements
Module: axi4_lite_regbank

Interface
REQ-001 SHALL have parameter SIZE_WORD, default 32, data bus width in bits (multiple of 8).
REQ-002 SHALL have parameter SIZE_STRB, default SIZE_WORD/8, write-strobe width.
REQ-003 SHALL have parameter SIZE_ADDR, default 32, byte-address width.
REQ-004 SHALL have parameter NUM_REGS, default 16, number of registers (1..256).
REQ-005 SHALL use one clock and a synchronous, active-high reset:
  - ACLK  in  1  clock; all logic on rising edge.
  - ARST  in  1  synchronous reset, active-high.
REQ-006 SHALL have the following write-address and write-data ports:
  - AWVALID/AWREADY  in/out  1  write-address handshake.
  - AWADDR  in  SIZE_ADDR  write byte address.
  - AWPROT  in  3  write protection.
  - WVALID/WREADY  in/out  1  write-data handshake.
  - WDATA  in  SIZE_WORD  write data.
  - WSTRB  in  SIZE_STRB  byte enables.
REQ-007 SHALL have the following write-response ports:
  - BVALID/BREADY  out/in  1  write-response handshake.
  - BRESP  out  2  00 OKAY, 10 SLVERR.
REQ-008 SHALL have the following read-address and read-data ports:
  - ARVALID/ARREADY  in/out  1  read-address handshake.
  - ARADDR  in  SIZE_ADDR  read byte address.
  - ARPROT  in  3  read protection.
  - RVALID/RREADY  out/in  1  read-data handshake.
  - RDATA  out  SIZE_WORD  read data.
  - RRESP  out  2  00 OKAY, 10 SLVERR.
REQ-009 SHALL have the following register-side ports:
  - REGS_Q  out  NUM_REGS*SIZE_WORD  register contents; register i at bits [i*SIZE_WORD +: SIZE_WORD].
  - WR_PULSE  out  NUM_REGS  one-cycle pulse, bit i set in the cycle register i is written.

Function
REQ-010 SHALL accept AW and W independently, each into its own one-entry holding buffer.
  - AWREADY = !aw_held && !BVALID.
  - WREADY = !w_held && !BVALID.
  - AW and W may arrive in any order or in the same cycle.
REQ-011 SHALL perform the write in the cycle after both buffers are full, as follows:
  - Update the selected register bytewise per WSTRB.
  - Pulse WR_PULSE.
  - Clear both buffers.
  - Assert BVALID in the same cycle.
REQ-012 SHALL hold BVALID and BRESP stable until BREADY; BVALID falls in the cycle after the BVALID&&BREADY handshake.
REQ-013 write FSM states SHALL be:
  - W_COLLECT: buffers filling.
  - W_RESP: BVALID high.
  - W_RESP returns to W_COLLECT on the B handshake.
REQ-014 SHALL decode the register index as ADDR[log2(SIZE_STRB) +: 8]; address bits below the word boundary are ignored (unaligned access treated as aligned).
REQ-015 SHALL treat index >= NUM_REGS as an error.
  - Write: discarded, no WR_PULSE, BRESP=10.
  - Read: RDATA=0, RRESP=10.
REQ-016 SHALL set ARREADY = !RVALID.
REQ-017 SHALL handle a read as follows:
  - On the AR handshake, register RDATA/RRESP and assert RVALID in the next cycle (latency 1).
  - Hold RDATA/RRESP/RVALID until RREADY.
REQ-018 read FSM states SHALL be:
  - R_IDLE: ARREADY high.
  - R_DATA: RVALID high.
  - R_DATA returns to R_IDLE on the R handshake.
REQ-019 SHALL run the read and write paths concurrently.
  - A read of register i sampled in the same cycle that register i is written SHALL return the pre-write value.
REQ-020 WSTRB=0 SHALL complete with OKAY, leave the data unchanged, and still pulse WR_PULSE.
REQ-021 SHALL never drop or duplicate a transaction under arbitrary VALID/READY back-pressure.

Reset
REQ-022 On ARST high at a clock edge, the block SHALL:
  - Clear every register to 0.
  - Empty both holding buffers.
  - Return the FSMs to W_COLLECT/R_IDLE.
  - Drive AWREADY=WREADY=ARREADY=0 during reset, then 1 from the first cycle after ARST falls.
  - Drive BVALID=RVALID=0, BRESP=RRESP=00, RDATA=0, WR_PULSE=0.
REQ-023 Reset asserted mid-transaction SHALL abandon that transaction with no response issued.

Configuration
REQ-024 Macro AXIL_REGBANK_PROT_EN SHALL control protection checking.
  - Defined: any access with PROT[0]=0 (unprivileged) completes with SLVERR; writes are discarded with no WR_PULSE; reads return RDATA=0.
  - Undefined: AWPROT/ARPROT are ignored.

Verification
REQ-025 Bench SHALL drive AW 0x08 and W 0xDEADBEEF with WSTRB=1111 in the same cycle, BREADY=1; required response: BVALID 1 cycle later, BRESP=00, register 2=0xDEADBEEF, WR_PULSE[2] pulses once.
REQ-026 Bench SHALL drive W 0x000000AA with WSTRB=0001 three cycles before AW 0x0C, with register 3 preloaded to 0x11223344; required response: register 3=0x112233AA, one B response.
REQ-027 Bench SHALL write 0x12345678 to register 1, then read ARADDR 0x04 with RREADY held low for 4 cycles; required response: RVALID high, RDATA=0x12345678 stable, ARREADY=0 until the R handshake.
REQ-028 Bench SHALL issue a write and a read to ARADDR 0x40 with NUM_REGS=16; required response: BRESP=10 with no register change, RRESP=10 with RDATA=0.
REQ-029 Bench SHALL assert ARST while BVALID is high and waiting; required response: BVALID=0 next cycle, all REGS_Q=0, AWREADY=1 in the first cycle after ARST falls.
REQ-030 Bench SHALL build with AXIL_REGBANK_PROT_EN defined and write AWPROT=000 to 0x00; required response: BRESP=10, register 0 unchanged.

Source files
------------

// File: rtl/axi4_lite_regbank.sv
// AXI4-Lite slave exposing NUM_REGS read/write registers with per-register write pulses.
// Optional macro AXIL_REGBANK_PROT_EN: reject unprivileged (PROT[0]=0) accesses with SLVERR.
module axi4_lite_regbank #(
    parameter int SIZE_WORD = 32,
    parameter int SIZE_STRB = SIZE_WORD / 8,
    parameter int SIZE_ADDR = 32,
    parameter int NUM_REGS  = 16
) (
    input  logic                          ACLK,
    input  logic                          ARST,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [SIZE_ADDR-1:0]          AWADDR,
    input  logic [2:0]                    AWPROT,
    input  logic                          WVALID,
    output logic                          WREADY,
    input  logic [SIZE_WORD-1:0]          WDATA,
    input  logic [SIZE_STRB-1:0]          WSTRB,
    output logic                          BVALID,
    input  logic                          BREADY,
    output logic [1:0]                    BRESP,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    input  logic [SIZE_ADDR-1:0]          ARADDR,
    input  logic [2:0]                    ARPROT,
    output logic                          RVALID,
    input  logic                          RREADY,
    output logic [SIZE_WORD-1:0]          RDATA,
    output logic [1:0]                    RRESP,
    output logic [NUM_REGS*SIZE_WORD-1:0] REGS_Q,
    output logic [NUM_REGS-1:0]           WR_PULSE
);

    localparam int ADDR_LSB = (SIZE_STRB > 1) ? $clog2(SIZE_STRB) : 0;

    typedef enum logic {W_COLLECT, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t r_wstate, w_wstate_nxt;
    rstate_t r_rstate, w_rstate_nxt;

    logic                               r_aw_held, r_aw_err;
    logic [7:0]                         r_aw_idx;
    logic                               r_w_held;
    logic [SIZE_WORD-1:0]               r_w_data;
    logic [SIZE_STRB-1:0]               r_w_strb;
    logic [1:0]                         r_bresp, r_rresp;
    logic [SIZE_WORD-1:0]               r_rdata;
    logic [NUM_REGS-1:0][SIZE_WORD-1:0] r_regs;
    logic [NUM_REGS-1:0]                r_wr_pulse;

    logic [7:0]           w_aw_idx, w_ar_idx;
    logic                 w_aw_err, w_ar_err, w_aw_oob, w_ar_oob;
    logic                 w_aw_hs, w_w_hs, w_ar_hs;
    logic                 w_do_write, w_bvalid, w_rvalid;
    logic [SIZE_WORD-1:0] w_rd_word;
    logic                 w_unused;

    // Bits outside the index field and the non-privilege PROT bits are don't-cares.
    assign w_unused = ^{AWADDR, ARADDR, AWPROT, ARPROT};

    assign w_aw_idx = AWADDR[ADDR_LSB +: 8];
    assign w_ar_idx = ARADDR[ADDR_LSB +: 8];
    assign w_aw_oob = ({1'b0, w_aw_idx} >= 9'(NUM_REGS));
    assign w_ar_oob = ({1'b0, w_ar_idx} >= 9'(NUM_REGS));

`ifdef AXIL_REGBANK_PROT_EN
    assign w_aw_err = w_aw_oob || !AWPROT[0];
    assign w_ar_err = w_ar_oob || !ARPROT[0];
`else
    assign w_aw_err = w_aw_oob;
    assign w_ar_err = w_ar_oob;
`endif

    // Write FSM: commit one cycle after both holding buffers are full.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_do_write   = 1'b0;
        w_bvalid     = 1'b0;
        case (r_wstate)
            W_COLLECT: begin
                if (r_aw_held && r_w_held) begin
                    w_do_write   = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (BREADY) w_wstate_nxt = W_COLLECT;
            end
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rvalid     = 1'b0;
        case (r_rstate)
            R_IDLE: if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA: begin
                w_rvalid = 1'b1;
                if (RREADY) w_rstate_nxt = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_wstate <= W_COLLECT;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    assign AWREADY = !ARST && !r_aw_held && !w_bvalid;
    assign WREADY  = !ARST && !r_w_held && !w_bvalid;
    assign ARREADY = !ARST && !w_rvalid;
    assign w_aw_hs = AWVALID && AWREADY;
    assign w_w_hs  = WVALID && WREADY;
    assign w_ar_hs = ARVALID && ARREADY;

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_aw_held  <= 1'b0;
            r_aw_err   <= 1'b0;
            r_aw_idx   <= '0;
            r_w_held   <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_bresp    <= 2'b00;
            r_regs     <= '0;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= w_aw_idx;
                r_aw_err  <= w_aw_err;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_w_data <= WDATA;
                r_w_strb <= WSTRB;
            end
            if (w_do_write) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bresp   <= r_aw_err ? 2'b10 : 2'b00;
                if (!r_aw_err) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (r_aw_idx == 8'(i)) begin
                            r_wr_pulse[i] <= 1'b1;
                            for (int b = 0; b < SIZE_STRB; b++)
                                if (r_w_strb[b]) r_regs[i][b*8 +: 8] <= r_w_data[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read mux samples pre-write contents, so a same-cycle write is not visible.
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (w_ar_idx == 8'(i)) w_rd_word = r_regs[i];
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_rdata <= '0;
            r_rresp <= 2'b00;
        end else if (w_ar_hs) begin
            r_rdata <= w_ar_err ? '0 : w_rd_word;
            r_rresp <= w_ar_err ? 2'b10 : 2'b00;
        end
    end

    assign BVALID   = w_bvalid;
    assign BRESP    = r_bresp;
    assign RVALID   = w_rvalid;
    assign RDATA    = r_rdata;
    assign RRESP    = r_rresp;
    assign REGS_Q   = r_regs;
    assign WR_PULSE = r_wr_pulse;

endmodule

// File: tb/tb_axi4_lite_regbank.sv
// Scoreboard bench for axi4_lite_regbank: directed corner cases plus randomized traffic
// checked against an array-based register model.
module tb_axi4_lite_regbank;
    localparam int SW = 32, SS = 4, SA = 32, NR = 16;
`ifdef AXIL_REGBANK_PROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic ACLK = 1'b0, ARST = 1'b1;
    logic AWVALID = 1'b0, WVALID = 1'b0, ARVALID = 1'b0;
    logic BREADY = 1'b0, RREADY = 1'b0;
    logic [SA-1:0] AWADDR = '0, ARADDR = '0;
    logic [2:0] AWPROT = '0, ARPROT = '0;
    logic [SW-1:0] WDATA = '0;
    logic [SS-1:0] WSTRB = '0;
    logic AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0] BRESP, RRESP;
    logic [SW-1:0] RDATA;
    logic [NR*SW-1:0] REGS_Q;
    logic [NR-1:0] WR_PULSE;

    axi4_lite_regbank #(.SIZE_WORD(SW), .SIZE_STRB(SS), .SIZE_ADDR(SA), .NUM_REGS(NR)) dut (
        .ACLK(ACLK), .ARST(ARST),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .REGS_Q(REGS_Q), .WR_PULSE(WR_PULSE)
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0, n_fail = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    logic [NR*SW-1:0] m_regs = '0;
    int exp_pulse[NR];
    int pulse_cnt[NR];
    int b_cnt = 0;
    int bmode = 1, rmode = 1;   // 0 low, 1 high, 2 random
    logic [1:0]  eb;
    logic [33:0] er;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_regs(input string nm);
        n_chk++;
        if (REGS_Q !== m_regs) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, REGS_Q, m_regs);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    always begin
        @(posedge ACLK);
        #2;
        BREADY = (bmode == 2) ? 1'($urandom_range(0, 1)) : (bmode == 1);
        RREADY = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
    end

    always @(negedge ACLK)
        for (int i = 0; i < NR; i++) if (WR_PULSE[i] === 1'b1) pulse_cnt[i]++;

    // Monitor: pops an expectation at every B/R handshake.
    always @(negedge ACLK) begin
        if (!ARST && BVALID && BREADY) begin
            b_cnt++;
            if (bq.size() == 0) timeout("b_unexpected");
            else begin
                eb = bq.pop_front();
                chk("bresp", BRESP, eb);
                chk_regs("regs_after_write");
            end
        end
        if (!ARST && RVALID && RREADY) begin
            if (rq.size() == 0) timeout("r_unexpected");
            else begin
                er = rq.pop_front();
                chk("rresp", RRESP, er[33:32]);
                chk("rdata", RDATA, er[31:0]);
            end
        end
    end

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 4) % 256);
    endfunction

    function automatic bit err_of(input logic [31:0] a, input logic [2:0] p);
        return (idx_of(a) >= NR) || (PROT_EN && !p[0]);
    endfunction

    function automatic int pulse_diffs();
        int n = 0;
        for (int i = 0; i < NR; i++) if (pulse_cnt[i] != exp_pulse[i]) n++;
        return n;
    endfunction

    task automatic aw_send(input logic [31:0] a, input logic [2:0] p, input int d);
        bit hs;
        repeat (d) begin @(posedge ACLK); #1; end
        AWADDR = a; AWPROT = p; AWVALID = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge ACLK); hs = AWREADY;
            @(posedge ACLK); #1;
            if (hs) break;
            if (t > 100) begin timeout("aw_handshake"); break; end
        end
        AWVALID = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] dat, input logic [3:0] s, input int d);
        bit hs;
        repeat (d) begin @(posedge ACLK); #1; end
        WDATA = dat; WSTRB = s; WVALID = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge ACLK); hs = WREADY;
            @(posedge ACLK); #1;
            if (hs) break;
            if (t > 100) begin timeout("w_handshake"); break; end
        end
        WVALID = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [2:0] p, input int d);
        bit hs;
        repeat (d) begin @(posedge ACLK); #1; end
        ARADDR = a; ARPROT = p; ARVALID = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge ACLK); hs = ARREADY;
            @(posedge ACLK); #1;
            if (hs) break;
            if (t > 100) begin timeout("ar_handshake"); break; end
        end
        ARVALID = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 200; t++) begin
            if (bq.size() == 0 && rq.size() == 0 && !BVALID && !RVALID) return;
            @(posedge ACLK); #1;
        end
        timeout("idle");
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s,
                            input logic [2:0] p, input int awd, input int wd, output int lat);
        int i;
        i = idx_of(a);
        if (err_of(a, p)) bq.push_back(2'b10);
        else begin
            bq.push_back(2'b00);
            for (int b = 0; b < 4; b++) if (s[b]) m_regs[i*SW + b*8 +: 8] = dat[b*8 +: 8];
            exp_pulse[i]++;
        end
        fork
            aw_send(a, p, awd);
            w_send(dat, s, wd);
        join
        lat = 0;
        while (!BVALID && lat < 50) begin @(posedge ACLK); #1; lat++; end
        wait_idle();
        chk("wr_pulse_mismatches", pulse_diffs(), 0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [2:0] p, input int d);
        if (err_of(a, p)) rq.push_back({2'b10, 32'h0});
        else rq.push_back({2'b00, m_regs[idx_of(a)*SW +: SW]});
        ar_send(a, p, d);
        wait_idle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, idx;
        logic [31:0] a;
        for (int i = 0; i < NR; i++) begin exp_pulse[i] = 0; pulse_cnt[i] = 0; end

        // Reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("awready_in_reset", AWREADY, 0);
        chk("wready_in_reset", WREADY, 0);
        chk("arready_in_reset", ARREADY, 0);
        chk("bvalid_reset", BVALID, 0);
        chk("rvalid_reset", RVALID, 0);
        chk("bresp_reset", BRESP, 0);
        chk("rresp_reset", RRESP, 0);
        chk("rdata_reset", RDATA, 0);
        chk("wr_pulse_reset", WR_PULSE, 0);
        chk_regs("regs_reset");
        @(posedge ACLK); #1;
        ARST = 1'b0;
        @(negedge ACLK);
        chk("awready_after_reset", AWREADY, 1);
        chk("wready_after_reset", WREADY, 1);
        chk("arready_after_reset", ARREADY, 1);
        @(posedge ACLK); #1;

        // AW and W together
        do_write(32'h08, 32'hDEADBEEF, 4'hF, 3'b001, 0, 0, lat);
        chk("b_latency", lat, 1);
        chk("reg2", REGS_Q[2*SW +: SW], 32'hDEADBEEF);

        // W three cycles ahead of AW, single byte lane
        do_write(32'h0C, 32'h11223344, 4'hF, 3'b001, 0, 0, lat);
        bc = b_cnt;
        do_write(32'h0C, 32'h000000AA, 4'h1, 3'b001, 3, 0, lat);
        chk("reg3_bytelane", REGS_Q[3*SW +: SW], 32'h112233AA);
        chk("b_count_one", b_cnt - bc, 1);

        // Empty strobe still completes and pulses
        do_write(32'h0C, 32'hFFFFFFFF, 4'h0, 3'b001, 1, 0, lat);
        chk("reg3_strb0", REGS_Q[3*SW +: SW], 32'h112233AA);

        // Read stalled by RREADY low
        do_write(32'h04, 32'h12345678, 4'hF, 3'b001, 0, 1, lat);
        rmode = 0;
        rq.push_back({2'b00, 32'h12345678});
        ar_send(32'h04, 3'b001, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge ACLK);
            chk("rvalid_hold", RVALID, 1);
            chk("rdata_hold", RDATA, 32'h12345678);
            chk("arready_blocked", ARREADY, 0);
            @(posedge ACLK); #1;
        end
        rmode = 1;
        wait_idle();

        // Out-of-range register
        do_write(32'h40, 32'hCAFEF00D, 4'hF, 3'b001, 0, 0, lat);
        do_read(32'h40, 3'b001, 0);

        // Unprivileged access: rejected only when protection checking is built in
        do_write(32'h00, 32'h55AA55AA, 4'hF, 3'b000, 0, 0, lat);
        do_read(32'h00, 3'b000, 0);

        // Read sampled on the same edge as a write to that register sees the old value
        do_write(32'h18, 32'hA5A5A5A5, 4'hF, 3'b001, 0, 0, lat);
        rq.push_back({2'b00, 32'hA5A5A5A5});
        fork
            do_write(32'h18, 32'h5A5A5A5A, 4'hF, 3'b001, 0, 0, lat);
            ar_send(32'h18, 3'b001, 1);
        join
        wait_idle();

        // Randomized traffic with back-pressure
        bmode = 2; rmode = 2;
        for (int n = 0; n < 80; n++) begin
            idx = $urandom_range(0, 19);
            a = ($urandom() & ~32'h3FC) | (32'(idx) << 2);
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom(), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                         $urandom_range(0, 3), $urandom_range(0, 3), lat);
            else
                do_read(a, 3'($urandom_range(0, 7)), $urandom_range(0, 2));
        end

        // Reset while a write response is waiting
        bmode = 0;
        #1;
        fork
            aw_send(32'h14, 3'b001, 0);
            w_send(32'h0BADF00D, 4'hF, 0);
        join
        exp_pulse[5]++;
        for (int t = 0; t < 10 && !BVALID; t++) begin @(posedge ACLK); #1; end
        chk("bvalid_waiting", BVALID, 1);
        ARST = 1'b1;
        @(negedge ACLK);
        chk("awready_during_reset", AWREADY, 0);
        @(posedge ACLK); #1;
        ARST = 1'b0;
        m_regs = '0;
        @(negedge ACLK);
        chk("bvalid_after_reset", BVALID, 0);
        chk_regs("regs_after_reset");
        chk("awready_post_reset", AWREADY, 1);
        chk("wready_post_reset", WREADY, 1);
        chk("arready_post_reset", ARREADY, 1);
        @(posedge ACLK); #1;
        bmode = 1;
        do_write(32'h14, 32'h0000BEEF, 4'h3, 3'b001, 0, 0, lat);
        do_read(32'h14, 3'b001, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
